// File: rtl/ad9958_pkg.sv
// Shared types and constants for the AD9958 two-channel frequency sweep scheduler.
package ad9958_pkg;

    localparam int FTW_W = 32;
    localparam int ASF_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_OFFER,
        ST_DWELL,
        ST_FINISH
    } state_e;

    // Per-sweep configuration that must not follow the inputs once a sweep is running.
    typedef struct packed {
        logic [FTW_W-1:0] step_ch0;
        logic [FTW_W-1:0] step_ch1;
        logic [ASF_W-1:0] asf_ch0;
        logic [ASF_W-1:0] asf_ch1;
    } shadow_t;

    function automatic logic [FTW_W-1:0] ftw_negate(input logic [FTW_W-1:0] v);
        return -v;
    endfunction

endpackage

// File: rtl/ad9958_dwell_timer.sv
// Loadable dwell down-counter; zero is flagged combinationally from the count register.
module ad9958_dwell_timer #(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               tick,
    output logic               zero
);

    logic [DWELL_W-1:0] count_d;
    logic [DWELL_W-1:0] count_q;

    // NOTE: every variable assigned in always_comb gets a default first; a path without an assignment infers a latch.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - DWELL_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/ad9958_sweep_sched.sv
// Sweep scheduler feeding FTW/ASF word sets to the AD9958 SPI master over a valid/ready handshake.
// Build option: define AD9958_PINGPONG_EN to sweep back and forth until abort instead of finishing once.
module ad9958_sweep_sched
    import ad9958_pkg::*;
#(
    parameter int unsigned DWELL_W = 16,
    parameter int unsigned STEP_W  = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [FTW_W-1:0]   ftw_start_ch0,
    input  logic [FTW_W-1:0]   ftw_start_ch1,
    input  logic [FTW_W-1:0]   ftw_step_ch0,
    input  logic [FTW_W-1:0]   ftw_step_ch1,
    input  logic [ASF_W-1:0]   asf_in_ch0,
    input  logic [ASF_W-1:0]   asf_in_ch1,
    input  logic [STEP_W-1:0]  n_steps,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               upd_ready,
    output logic [FTW_W-1:0]   ftw_ch0,
    output logic [FTW_W-1:0]   ftw_ch1,
    output logic [ASF_W-1:0]   asf_ch0,
    output logic [ASF_W-1:0]   asf_ch1,
    output logic               upd_valid,
    output logic               busy,
    output logic               done
);

    state_e             state_d,    state_q;
    shadow_t            shadow_d,   shadow_q;
    logic [STEP_W-1:0]  n_steps_d,  n_steps_q;
    logic [DWELL_W-1:0] dwell_d,    dwell_q;
    logic [STEP_W-1:0]  step_cnt_d, step_cnt_q;
    logic [FTW_W-1:0]   ftw_ch0_d,  ftw_ch0_q;
    logic [FTW_W-1:0]   ftw_ch1_d,  ftw_ch1_q;
    logic [ASF_W-1:0]   asf_ch0_d,  asf_ch0_q;
    logic [ASF_W-1:0]   asf_ch1_d,  asf_ch1_q;
    logic               upd_valid_d, upd_valid_q;
    logic               busy_d,     busy_q;
    logic               done_d,     done_q;

    logic tmr_load;
    logic tmr_tick;
    logic tmr_zero;

    ad9958_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (dwell_q),
        .tick     (tmr_tick),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        n_steps_d  = n_steps_q;
        dwell_d    = dwell_q;
        step_cnt_d = step_cnt_q;
        ftw_ch0_d  = ftw_ch0_q;
        ftw_ch1_d  = ftw_ch1_q;
        asf_ch0_d  = asf_ch0_q;
        asf_ch1_d  = asf_ch1_q;
        tmr_load   = 1'b0;
        tmr_tick   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Abort outranks start even when the block is already idle.
                if (start && !abort) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    shadow_d.step_ch0 = ftw_step_ch0;
                    shadow_d.step_ch1 = ftw_step_ch1;
                    shadow_d.asf_ch0  = asf_in_ch0;
                    shadow_d.asf_ch1  = asf_in_ch1;
                    n_steps_d         = n_steps;
                    dwell_d           = dwell;
                    ftw_ch0_d         = ftw_start_ch0;
                    ftw_ch1_d         = ftw_start_ch1;
                    asf_ch0_d         = asf_in_ch0;
                    asf_ch1_d         = asf_in_ch1;
                    step_cnt_d        = '0;
                    state_d           = ST_OFFER;
                end
            end

            ST_OFFER: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (upd_ready) begin
                    if (step_cnt_q == n_steps_q) begin
`ifdef AD9958_PINGPONG_EN
                        shadow_d.step_ch0 = ftw_negate(shadow_q.step_ch0);
                        shadow_d.step_ch1 = ftw_negate(shadow_q.step_ch1);
                        step_cnt_d        = '0;
                        tmr_load          = 1'b1;
                        state_d           = ST_DWELL;
`else
                        state_d = ST_FINISH;
`endif
                    end else begin
                        tmr_load = 1'b1;
                        state_d  = ST_DWELL;
                    end
                end
            end

            ST_DWELL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_zero) begin
                    // FTW arithmetic wraps modulo 2^32 by design; no saturation.
                    ftw_ch0_d  = ftw_ch0_q + shadow_q.step_ch0;
                    ftw_ch1_d  = ftw_ch1_q + shadow_q.step_ch1;
                    asf_ch0_d  = shadow_q.asf_ch0;
                    asf_ch1_d  = shadow_q.asf_ch1;
                    step_cnt_d = step_cnt_q + STEP_W'(1);
                    state_d    = ST_OFFER;
                end else begin
                    tmr_tick = 1'b1;
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_comb begin
        upd_valid_d = (state_d == ST_OFFER);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FINISH);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            n_steps_q   <= '0;
            dwell_q     <= '0;
            step_cnt_q  <= '0;
            ftw_ch0_q   <= '0;
            ftw_ch1_q   <= '0;
            asf_ch0_q   <= '0;
            asf_ch1_q   <= '0;
            upd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            n_steps_q   <= n_steps_d;
            dwell_q     <= dwell_d;
            step_cnt_q  <= step_cnt_d;
            ftw_ch0_q   <= ftw_ch0_d;
            ftw_ch1_q   <= ftw_ch1_d;
            asf_ch0_q   <= asf_ch0_d;
            asf_ch1_q   <= asf_ch1_d;
            upd_valid_q <= upd_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ftw_ch0   = ftw_ch0_q;
    assign ftw_ch1   = ftw_ch1_q;
    assign asf_ch0   = asf_ch0_q;
    assign asf_ch1   = asf_ch1_q;
    assign upd_valid = upd_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ad9958_sweep_sched.sv
// Directed bench for ad9958_sweep_sched; define AD9958_PINGPONG_EN to exercise the back-and-forth build.
module tb_ad9958_sweep_sched;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [31:0] ftw_start_ch0, ftw_start_ch1;
    logic [31:0] ftw_step_ch0,  ftw_step_ch1;
    logic [9:0]  asf_in_ch0,    asf_in_ch1;
    logic [15:0] n_steps;
    logic [15:0] dwell;
    logic        upd_ready;
    logic [31:0] ftw_ch0, ftw_ch1;
    logic [9:0]  asf_ch0, asf_ch1;
    logic        upd_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [31:0] xf0 [16];
    logic [31:0] xf1 [16];

    always #5 clock = ~clock;

    ad9958_sweep_sched #(
        .DWELL_W (16),
        .STEP_W  (16)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .ftw_start_ch0 (ftw_start_ch0),
        .ftw_start_ch1 (ftw_start_ch1),
        .ftw_step_ch0  (ftw_step_ch0),
        .ftw_step_ch1  (ftw_step_ch1),
        .asf_in_ch0    (asf_in_ch0),
        .asf_in_ch1    (asf_in_ch1),
        .n_steps       (n_steps),
        .dwell         (dwell),
        .upd_ready     (upd_ready),
        .ftw_ch0       (ftw_ch0),
        .ftw_ch1       (ftw_ch1),
        .asf_ch0       (asf_ch0),
        .asf_ch1       (asf_ch1),
        .upd_valid     (upd_valid),
        .busy          (busy),
        .done          (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [31:0] s0, input logic [31:0] st0,
                           input logic [31:0] s1, input logic [31:0] st1,
                           input logic [15:0] ns, input logic [15:0] dw);
        ftw_start_ch0 = s0;
        ftw_step_ch0  = st0;
        ftw_start_ch1 = s1;
        ftw_step_ch1  = st1;
        n_steps       = ns;
        dwell         = dw;
    endtask

    // Called at a negedge; start is sampled by the following posedge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Records each handshake seen at a negedge (it completes on the next posedge) until done or budget.
    task automatic collect(input int max_xfer, input int budget, output int n,
                           output int gap, output logic busy_at_done);
        int since;
        n            = 0;
        gap          = -1;
        since        = 0;
        busy_at_done = 1'bx;
        for (int i = 0; i < 16; i++) begin
            xf0[i] = 'x;
            xf1[i] = 'x;
        end
        for (int c = 0; c < budget; c++) begin
            if (done === 1'b1) begin
                gap          = since;
                busy_at_done = busy;
                break;
            end
            if (upd_valid === 1'b1 && upd_ready === 1'b1) begin
                xf0[n] = ftw_ch0;
                xf1[n] = ftw_ch1;
                n++;
                since = 0;
                if (n >= max_xfer) break;
            end
            @(negedge clock);
            since++;
        end
    endtask

    initial begin
        int          n;
        int          gap;
        logic        bad_busy;
        int          bad;
        logic [31:0] exp0 [8];
        logic [31:0] exp1 [8];

        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        upd_ready = 1'b1;
        asf_in_ch0 = 10'h155;
        asf_in_ch1 = 10'h2AA;
        set_cfg(32'd1000, 32'd500, 32'd7, 32'd3, 16'd3, 16'd0);
        #2;
        check("rst_ftw0",  ftw_ch0, 32'h0);
        check("rst_ftw1",  ftw_ch1, 32'h0);
        check("rst_asf",   {asf_ch0, asf_ch1}, 32'h0);
        check("rst_flags", {upd_valid, busy, done}, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

`ifdef AD9958_PINGPONG_EN
        set_cfg(32'd0, 32'd10, 32'd100, 32'd1, 16'd2, 16'd0);
        pulse_start();
        collect(8, 200, n, gap, bad_busy);
        check("pp_n", n, 8);
        check("pp_no_done", gap, -1);
        exp0 = '{0, 10, 20, 10, 0, 10, 20, 10};
        exp1 = '{100, 101, 102, 101, 100, 101, 102, 101};
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pp_p%0d_ch0", i), xf0[i], exp0[i]);
            check($sformatf("pp_p%0d_ch1", i), xf1[i], exp1[i]);
        end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("pp_abort_busy",  busy, 0);
        check("pp_abort_valid", upd_valid, 0);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) bad++;
            @(negedge clock);
        end
        check("pp_abort_quiet", bad, 0);
`else
        // Basic four-point sweep with dwell=0 and latency from start.
        set_cfg(32'd1000, 32'd500, 32'd7, 32'd3, 16'd3, 16'd0);
        pulse_start();
        check("t1_lat_load_valid", upd_valid, 0);
        check("t1_lat_load_busy",  busy, 1);
        @(negedge clock);
        check("t1_lat_offer_valid", upd_valid, 1);
        collect(8, 100, n, gap, bad_busy);
        check("t1_n", n, 4);
        exp0[0:3] = '{1000, 1500, 2000, 2500};
        exp1[0:3] = '{7, 10, 13, 16};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_p%0d_ch0", i), xf0[i], exp0[i]);
            check($sformatf("t1_p%0d_ch1", i), xf1[i], exp1[i]);
        end
        check("t1_done_gap", gap, 1);
        check("t1_busy_at_done", bad_busy, 1);
        check("t1_asf", {asf_ch0, asf_ch1}, {12'h0, 10'h155, 10'h2AA});
        @(negedge clock);
        check("t1_done_pulse", done, 0);
        check("t1_busy_end", busy, 0);

        // Single-point sweep.
        set_cfg(32'h12345678, 32'd1, 32'h0000ABCD, 32'd1, 16'd0, 16'd4);
        pulse_start();
        collect(8, 100, n, gap, bad_busy);
        check("t2_n", n, 1);
        check("t2_p0_ch0", xf0[0], 32'h12345678);
        check("t2_p0_ch1", xf1[0], 32'h0000ABCD);
        check("t2_done_gap", gap, 1);
        check("t2_busy_at_done", bad_busy, 1);
        @(negedge clock);
        check("t2_busy_falls", {busy, done}, 0);

        // Modulo-2^32 wrap on both channels, dwell=2.
        set_cfg(32'hFFFFFF00, 32'h200, 32'd5, 32'hFFFFFFFA, 16'd1, 16'd2);
        pulse_start();
        collect(8, 100, n, gap, bad_busy);
        check("t3_n", n, 2);
        check("t3_p0_ch0", xf0[0], 32'hFFFFFF00);
        check("t3_p1_ch0", xf0[1], 32'h00000100);
        check("t3_p1_ch1", xf1[1], 32'hFFFFFFFF);
        check("t3_done_gap", gap, 1);
        @(negedge clock);

        // Back-pressure: outputs frozen, start and config changes ignored mid-sweep.
        set_cfg(32'd100, 32'd10, 32'd200, 32'hFFFFFFFF, 16'd2, 16'd1);
        upd_ready = 1'b0;
        pulse_start();
        @(negedge clock);
        check("t4_valid_up", upd_valid, 1);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            if (upd_valid !== 1'b1 || ftw_ch0 !== 32'd100 || ftw_ch1 !== 32'd200 ||
                asf_ch0 !== 10'h155 || done !== 1'b0) bad++;
            if (c == 10) set_cfg(32'd5, 32'd77, 32'd9, 32'd9, 16'd0, 16'd0);
            start = (c == 20);
            @(negedge clock);
        end
        start = 1'b0;
        check("t4_stable_50", bad, 0);
        upd_ready = 1'b1;
        collect(8, 100, n, gap, bad_busy);
        check("t4_n", n, 3);
        exp0[0:2] = '{100, 110, 120};
        exp1[0:2] = '{200, 199, 198};
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t4_p%0d_ch0", i), xf0[i], exp0[i]);
            check($sformatf("t4_p%0d_ch1", i), xf1[i], exp1[i]);
        end
        check("t4_done_gap", gap, 1);
        @(negedge clock);

        // Start and abort in the same idle cycle: abort wins.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        check("t5_idle_abort_busy", busy, 0);
        @(negedge clock);
        check("t5_idle_abort_valid", {upd_valid, busy}, 0);

        // Abort during a long dwell, then a clean restart.
        set_cfg(32'd2000, 32'd1, 32'd50, 32'd2, 16'd3, 16'd100);
        pulse_start();
        @(negedge clock);
        check("t6_offer", upd_valid, 1);
        @(negedge clock);
        check("t6_dwell", {upd_valid, busy}, 32'h1);
        repeat (5) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("t6_abort_flags", {upd_valid, busy, done}, 0);
        check("t6_abort_ftw0", ftw_ch0, 32'd2000);
        check("t6_abort_ftw1", ftw_ch1, 32'd50);
        bad = 0;
        for (int c = 0; c < 120; c++) begin
            if (done !== 1'b0 || upd_valid !== 1'b0 || busy !== 1'b0 || ftw_ch0 !== 32'd2000) bad++;
            @(negedge clock);
        end
        check("t6_abort_quiet", bad, 0);
        dwell = 16'd0;
        pulse_start();
        collect(8, 100, n, gap, bad_busy);
        check("t6_restart_n", n, 4);
        exp0[0:3] = '{2000, 2001, 2002, 2003};
        exp1[0:3] = '{50, 52, 54, 56};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6_p%0d_ch0", i), xf0[i], exp0[i]);
            check($sformatf("t6_p%0d_ch1", i), xf1[i], exp1[i]);
        end
        check("t6_done_gap", gap, 1);
        @(negedge clock);
`endif

        // Asynchronous reset mid-sweep abandons it without a done pulse.
        set_cfg(32'h0BADF00D, 32'd1, 32'h0000BEEF, 32'd1, 16'd5, 16'd3);
        pulse_start();
        repeat (3) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_flags", {upd_valid, busy, done}, 0);
        check("rst_mid_ftw0", ftw_ch0, 32'h0);
        check("rst_mid_asf", {asf_ch0, asf_ch1}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (done !== 1'b0 || busy !== 1'b0 || upd_valid !== 1'b0) bad++;
            @(negedge clock);
        end
        check("rst_mid_quiet", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
